// File: rtl/paddle_button_conditioner.sv
// Button front end for the paddle: synchronize, debounce, and resolve two raw
// buttons into frame-coherent up/down levels with last-pressed-wins arbitration.
module paddle_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btnUpRaw,
  input  logic btnDownRaw,
  input  logic frameTick,
  output logic up,
  output logic down,
  output logic dbUp,
  output logic dbDown,
  output logic anyPress
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned      UP_IDX   = 0;
  localparam int unsigned      DN_IDX   = 1;

  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db;
  logic [1:0]       rise_c;
  logic [1:0]       rise;
  logic [CNT_W-1:0] cnt [2];
  state_t           state;

  // Everything past this point treats 1 as pressed.
  assign raw = BTN_ACTIVE_HIGH ? {btnDownRaw, btnUpRaw} : ~{btnDownRaw, btnUpRaw};

  // A debounced level is about to rise on this edge.
  always_comb begin
    rise_c = '0;
    for (int i = 0; i < 2; i++) begin
      rise_c[i] = sync2[i] & ~db[i] & (cnt[i] == CNT_LAST);
    end
  end

  // Synchronizers, debouncers and press detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db       <= '0;
      rise     <= '0;
      anyPress <= 1'b0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      rise     <= rise_c;
      anyPress <= |rise_c;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign dbUp   = db[UP_IDX];
  assign dbDown = db[DN_IDX];

  // Direction arbitration; a fresh press always takes over the other direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise[UP_IDX] && !rise[DN_IDX])            state <= MOVE_UP;
          else if (rise[DN_IDX] && !rise[UP_IDX])       state <= MOVE_DOWN;
          else if (rise[DN_IDX] && rise[UP_IDX])        state <= IDLE;
          else if (db[UP_IDX] && !db[DN_IDX])           state <= MOVE_UP;
          else if (db[DN_IDX] && !db[UP_IDX])           state <= MOVE_DOWN;
          else                                          state <= IDLE;
        end
        MOVE_UP: begin
          if (rise[DN_IDX])                             state <= MOVE_DOWN;
          else if (!db[UP_IDX] && db[DN_IDX])           state <= MOVE_DOWN;
          else if (!db[UP_IDX] && !db[DN_IDX])          state <= IDLE;
          else                                          state <= MOVE_UP;
        end
        MOVE_DOWN: begin
          if (rise[UP_IDX])                             state <= MOVE_UP;
          else if (!db[DN_IDX] && db[UP_IDX])           state <= MOVE_UP;
          else if (!db[DN_IDX] && !db[UP_IDX])          state <= IDLE;
          else                                          state <= MOVE_DOWN;
        end
        default:                                        state <= IDLE;
      endcase
    end
  end

  // Direction levels only update on the frame tick, from the pre-edge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      up   <= 1'b0;
      down <= 1'b0;
    end else if (frameTick) begin
      up   <= (state == MOVE_UP);
      down <= (state == MOVE_DOWN);
    end
  end

endmodule

// File: tb/tb_paddle_button_conditioner.sv
// Directed bench for paddle_button_conditioner with a short debounce window;
// a second instance with inverted button polarity sees the complemented inputs.
module tb_paddle_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_up, btn_down, frame_tick;
  logic up, down, db_up, db_down, any_press;
  logic n_up, n_down, n_db_up, n_db_down, n_any_press;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  paddle_button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .BTN_ACTIVE_HIGH(1'b1)) dut (
    .clk(clk), .reset(reset), .btnUpRaw(btn_up), .btnDownRaw(btn_down),
    .frameTick(frame_tick), .up(up), .down(down), .dbUp(db_up), .dbDown(db_down),
    .anyPress(any_press)
  );

  paddle_button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .BTN_ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .reset(reset), .btnUpRaw(~btn_up), .btnDownRaw(~btn_down),
    .frameTick(frame_tick), .up(n_up), .down(n_down), .dbUp(n_db_up), .dbDown(n_db_down),
    .anyPress(n_any_press)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  // Release everything and let both instances return to IDLE with outputs low.
  task automatic settle();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(10);
    frame();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_up = 1'b1; btn_down = 1'b0; frame_tick = 1'b1;
    step(8);
    n_cmp++; if (up !== 1'b0)        begin n_err++; $display("FAIL reset_up: got %b want 0", up); end
    n_cmp++; if (down !== 1'b0)      begin n_err++; $display("FAIL reset_down: got %b want 0", down); end
    n_cmp++; if (db_up !== 1'b0)     begin n_err++; $display("FAIL reset_dbup: got %b want 0", db_up); end
    n_cmp++; if (db_down !== 1'b0)   begin n_err++; $display("FAIL reset_dbdown: got %b want 0", db_down); end
    n_cmp++; if (any_press !== 1'b0) begin n_err++; $display("FAIL reset_anypress: got %b want 0", any_press); end
    n_cmp++; if (n_db_up !== 1'b0)   begin n_err++; $display("FAIL reset_n_dbup: got %b want 0", n_db_up); end
    n_cmp++; if (n_up !== 1'b0)      begin n_err++; $display("FAIL reset_n_up: got %b want 0", n_up); end
    btn_up = 1'b0; frame_tick = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_press();
    btn_up = 1'b1;
    step(5);
    n_cmp++; if (db_up !== 1'b0)     begin n_err++; $display("FAIL press_dbup_early: got %b want 0", db_up); end
    n_cmp++; if (any_press !== 1'b0) begin n_err++; $display("FAIL press_any_early: got %b want 0", any_press); end
    step(1);
    n_cmp++; if (db_up !== 1'b1)     begin n_err++; $display("FAIL press_dbup: got %b want 1", db_up); end
    n_cmp++; if (any_press !== 1'b1) begin n_err++; $display("FAIL press_any: got %b want 1", any_press); end
    n_cmp++; if (up !== 1'b0)        begin n_err++; $display("FAIL press_up_pre_tick: got %b want 0", up); end
    step(1);
    n_cmp++; if (any_press !== 1'b0) begin n_err++; $display("FAIL press_any_width: got %b want 0", any_press); end
    frame();
    n_cmp++; if (up !== 1'b1)        begin n_err++; $display("FAIL press_up: got %b want 1", up); end
    n_cmp++; if (down !== 1'b0)      begin n_err++; $display("FAIL press_down: got %b want 0", down); end
    settle();
    n_cmp++; if (up !== 1'b0)        begin n_err++; $display("FAIL press_release_up: got %b want 0", up); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    btn_down = 1'b1;
    step(3);
    btn_down = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (db_down !== 1'b0) begin n_err++; $display("FAIL glitch_dbdown[%0d]: got %b want 0", i, db_down); end
      if (any_press === 1'b1) pulses++;
      step(1);
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL glitch_anypress: got %0d pulses want 0", pulses); end
    frame();
    n_cmp++; if (down !== 1'b0) begin n_err++; $display("FAIL glitch_down: got %b want 0", down); end
  endtask

  task automatic test_last_pressed();
    btn_up = 1'b1;
    step(8);
    frame();
    n_cmp++; if (up !== 1'b1) begin n_err++; $display("FAIL lpw_up_first: got %b want 1", up); end
    step(11);
    btn_down = 1'b1;
    step(7);
    frame();
    n_cmp++; if (up !== 1'b0)   begin n_err++; $display("FAIL lpw_up_after_down: got %b want 0", up); end
    n_cmp++; if (down !== 1'b1) begin n_err++; $display("FAIL lpw_down: got %b want 1", down); end
    btn_down = 1'b0;
    step(7);
    frame();
    n_cmp++; if (up !== 1'b1)   begin n_err++; $display("FAIL lpw_up_return: got %b want 1", up); end
    n_cmp++; if (down !== 1'b0) begin n_err++; $display("FAIL lpw_down_release: got %b want 0", down); end
    settle();
  endtask

  task automatic test_tie();
    int pulses = 0;
    btn_up = 1'b1; btn_down = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (any_press === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL tie_anypress: got %0d pulses want 1", pulses); end
    for (int k = 0; k < 2; k++) begin
      frame();
      n_cmp++; if (up !== 1'b0)   begin n_err++; $display("FAIL tie_up[%0d]: got %b want 0", k, up); end
      n_cmp++; if (down !== 1'b0) begin n_err++; $display("FAIL tie_down[%0d]: got %b want 0", k, down); end
    end
    btn_up = 1'b0;
    step(7);
    frame();
    n_cmp++; if (down !== 1'b1) begin n_err++; $display("FAIL tie_release_down: got %b want 1", down); end
    n_cmp++; if (up !== 1'b0)   begin n_err++; $display("FAIL tie_release_up: got %b want 0", up); end
    settle();
  endtask

  task automatic test_frame_tick();
    btn_up = 1'b1;
    step(10);
    n_cmp++; if (up !== 1'b0) begin n_err++; $display("FAIL notick_held: got %b want 0", up); end
    btn_up = 1'b0;
    step(10);
    n_cmp++; if (up !== 1'b0) begin n_err++; $display("FAIL notick_released: got %b want 0", up); end
    btn_up = 1'b1;
    step(6);
    frame();
    n_cmp++; if (up !== 1'b0) begin n_err++; $display("FAIL coincident_tick: got %b want 0", up); end
    step(3);
    frame();
    n_cmp++; if (up !== 1'b1) begin n_err++; $display("FAIL following_tick: got %b want 1", up); end
    // Back-to-back ticks reload the same level.
    frame();
    frame();
    n_cmp++; if (up !== 1'b1) begin n_err++; $display("FAIL back_to_back: got %b want 1", up); end
    settle();
  endtask

  task automatic test_reset_mid_press();
    btn_up = 1'b1;
    step(8);
    frame();
    n_cmp++; if (up !== 1'b1) begin n_err++; $display("FAIL rmp_up_before: got %b want 1", up); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++; if (up !== 1'b0)      begin n_err++; $display("FAIL rmp_up_cleared: got %b want 0", up); end
    n_cmp++; if (db_up !== 1'b0)   begin n_err++; $display("FAIL rmp_dbup_cleared: got %b want 0", db_up); end
    n_cmp++; if (down !== 1'b0)    begin n_err++; $display("FAIL rmp_down_cleared: got %b want 0", down); end
    step(5);
    n_cmp++; if (db_up !== 1'b0)     begin n_err++; $display("FAIL rmp_dbup_early: got %b want 0", db_up); end
    step(1);
    n_cmp++; if (db_up !== 1'b1)     begin n_err++; $display("FAIL rmp_dbup_rise: got %b want 1", db_up); end
    n_cmp++; if (any_press !== 1'b1) begin n_err++; $display("FAIL rmp_anypress: got %b want 1", any_press); end
    step(1);
    frame();
    n_cmp++; if (up !== 1'b1) begin n_err++; $display("FAIL rmp_up_after: got %b want 1", up); end
    settle();
  endtask

  task automatic test_active_low();
    btn_up = 1'b1;
    step(5);
    n_cmp++; if (n_db_up !== 1'b0)     begin n_err++; $display("FAIL al_dbup_early: got %b want 0", n_db_up); end
    step(1);
    n_cmp++; if (n_db_up !== 1'b1)     begin n_err++; $display("FAIL al_dbup: got %b want 1", n_db_up); end
    n_cmp++; if (n_any_press !== 1'b1) begin n_err++; $display("FAIL al_anypress: got %b want 1", n_any_press); end
    step(1);
    n_cmp++; if (n_any_press !== 1'b0) begin n_err++; $display("FAIL al_any_width: got %b want 0", n_any_press); end
    frame();
    n_cmp++; if (n_up !== 1'b1)        begin n_err++; $display("FAIL al_up: got %b want 1", n_up); end
    n_cmp++; if (n_down !== 1'b0)      begin n_err++; $display("FAIL al_down: got %b want 0", n_down); end
    n_cmp++; if (n_db_down !== 1'b0)   begin n_err++; $display("FAIL al_dbdown: got %b want 0", n_db_down); end
    settle();
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; frame_tick = 1'b0;
    test_reset();
    test_press();
    test_glitch();
    test_last_pressed();
    test_tie();
    test_frame_tick();
    test_reset_mid_press();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
